// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter that shares the single write port of one fifo between
// N producers. A producer is granted ownership for a burst of at most
// MAX_BURST words. Ownership then rotates, with one IDLE bubble cycle between
// grants. Writes are suppressed while the fifo reports full.
//
// Ports
//   clk_i            rising-edge clock
//   reset_ni         asynchronous active-low reset
//   req_valid_i      per-requester valid
//   req_data_i       requester k data in bits [k*WIDTH +: WIDTH]
//   req_ready_o      per-requester ready (at most one bit high)
//   fifo_full_i      fifo full flag (registered inside the fifo)
//   fifo_write_en_o  fifo write enable
//   fifo_data_o      fifo write data (0 when not writing)
//   grant_o          one-hot current owner, 0 when idle
//   grant_id_o       index of current owner, 0 when idle
//   busy_o           high while a requester owns the port
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
    parameter  int N         = 4,
    parameter  int WIDTH     = 16,
    parameter  int MAX_BURST = 4,
    localparam int IDW       = (N > 1) ? $clog2(N) : 1,
    localparam int CW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [N-1:0]       req_valid_i,
    input  logic [N*WIDTH-1:0] req_data_i,
    output logic [N-1:0]       req_ready_o,
    input  logic               fifo_full_i,
    output logic               fifo_write_en_o,
    output logic [WIDTH-1:0]   fifo_data_o,
    output logic [N-1:0]       grant_o,
    output logic [IDW-1:0]     grant_id_o,
    output logic               busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [IDW-1:0] owner, owner_n;
    logic [CW-1:0]  burst_cnt, burst_cnt_n;
    logic [IDW-1:0] rr_ptr, rr_ptr_n;

    logic           sel_found;
    logic [IDW-1:0] sel_idx;
    logic           owner_valid;
    logic           transfer;
    logic           last_word;
    logic           release_own;

    // Round-robin pick: first valid requester scanning rr_ptr, rr_ptr+1, ...
    always_comb begin
        // NOTE: every signal driven here gets a default before any branch so
        // no path leaves it unassigned, which would otherwise infer a latch.
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (int'(rr_ptr) + i) % N;
            if (!sel_found && req_valid_i[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(idx);
            end
        end
    end

    assign owner_valid = req_valid_i[owner];
    assign transfer    = (state == OWN) && owner_valid && !fifo_full_i;
    assign last_word   = (burst_cnt == CW'(MAX_BURST - 1));
    // Dropping valid forfeits the grant; a full stall alone never does.
    assign release_own = (state == OWN) && (!owner_valid || (transfer && last_word));

    // Next-state logic
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        burst_cnt_n = burst_cnt;
        rr_ptr_n    = rr_ptr;
        unique case (state)
            IDLE: begin
                if (sel_found) begin
                    state_n     = OWN;
                    owner_n     = sel_idx;
                    burst_cnt_n = '0;
                end
            end
            OWN: begin
                if (transfer) begin
                    burst_cnt_n = burst_cnt + CW'(1);
                end
                if (release_own) begin
                    state_n     = IDLE;
                    burst_cnt_n = '0;
                    rr_ptr_n    = (owner == IDW'(N - 1)) ? '0 : owner + IDW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= IDLE;
            owner     <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state     <= state_n;
            owner     <= owner_n;
            burst_cnt <= burst_cnt_n;
            rr_ptr    <= rr_ptr_n;
        end
    end

    // Outputs: all derived from registered state, so they fall to 0 as soon
    // as the asynchronous reset forces IDLE.
    always_comb begin
        req_ready_o     = '0;
        grant_o         = '0;
        fifo_write_en_o = transfer;
        fifo_data_o     = '0;
        busy_o          = (state == OWN);
        grant_id_o      = '0;
        if (state == OWN) begin
            req_ready_o[owner] = !fifo_full_i;
            grant_o[owner]     = 1'b1;
            grant_id_o         = owner;
        end
        if (transfer) begin
            fifo_data_o = req_data_i[int'(owner) * WIDTH +: WIDTH];
        end
    end

endmodule
